// File: rtl/systemizer_pkg.sv
// Shared types and size derivations for the systemizer scheduler.
package systemizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_SYS_START,
        ST_SYS_WAIT,
        ST_READ,
        ST_FINISH
    } state_t;

    function automatic int calc_words(input int l, input int k, input int n);
        return (l * k) / n;
    endfunction

    // Address width never collapses to zero, even for a single-word matrix.
    function automatic int calc_aw(input int l, input int k, input int n);
        int w;
        w = calc_words(l, k, n);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    function automatic int calc_tw(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/systemizer_sched_if.sv
// Ready/valid word stream carrying the systemized matrix out of the scheduler.
interface systemizer_sched_if #(
    parameter int N = 20
);
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/systemizer_sched_skid_fifo2.sv
// Two-entry ready/valid word buffer with occupancy count; head reads as zero when empty.
module skid_fifo2 #(
    parameter int N = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic [N-1:0] head,
    output logic [1:0]   occ
);

    logic [N-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = (occ != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/systemizer_sched.sv
// Key-request sequencer: matrix generation, bounded systemizer retries, result streaming
// and host debug-read arbitration of the systemizer read port.
//   state        | meaning
//   ST_IDLE      | waiting for req; host reads served
//   ST_GEN       | matrix generator running, wait gen_done
//   ST_SYS_START | one cycle; sys_start pulses on the following cycle
//   ST_SYS_WAIT  | wait for systemizer success/fail
//   ST_READ      | stream WORDS words through the 2-entry buffer
//   ST_FINISH    | key_ok pulse
module systemizer_sched
    import systemizer_pkg::*;
#(
    parameter  int N         = 20,
    parameter  int L         = 200,
    parameter  int K         = 400,
    parameter  int MAX_TRIES = 8,
    localparam int WORDS     = calc_words(L, K, N),
    localparam int AW        = calc_aw(L, K, N),
    localparam int TW        = calc_tw(MAX_TRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    output logic                      gen_req,
    input  logic                      gen_done,
    output logic                      sys_start,
    input  logic                      sys_success,
    input  logic                      sys_fail,
    output logic                      sys_rd_en,
    output logic [AW-1:0]             sys_rd_addr,
    input  logic [N-1:0]              sys_data_out,
    systemizer_sched_if.master        strm,
    input  logic                      host_rd_req,
    input  logic [AW-1:0]             host_rd_addr,
    output logic                      host_rd_gnt,
    output logic                      host_rd_valid,
    output logic [N-1:0]              host_data,
    output logic                      busy,
    output logic                      key_ok,
    output logic                      key_abort,
    output logic [TW-1:0]             tries
);

    state_t         state, state_nxt;
    logic           gen_req_nxt;
    logic           abort_nxt;
    logic [TW-1:0]  tries_nxt;
    logic [AW-1:0]  rd_addr;
    logic           rd_all;
    logic           rd_pend;
    logic [AW-1:0]  out_cnt;
    logic [1:0]     occ;
    logic [N-1:0]   head;
    logic           pop;
    logic           room;
    logic           stream_rd_en;

    skid_fifo2 #(.N(N)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (sys_data_out),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign strm.out_valid = (occ != 2'd0);
    assign strm.out_data  = head;
    assign strm.out_last  = strm.out_valid && (out_cnt == AW'(WORDS - 1));
    assign pop            = strm.out_valid && strm.out_ready;

    // Credit counts the word leaving this cycle so a continuously ready sink sees one word per cycle.
    assign room         = (({1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2);
    assign stream_rd_en = (state == ST_READ) && !rd_all && room;

    assign host_rd_gnt = host_rd_req && (state == ST_IDLE) && !req;
    assign sys_rd_en   = stream_rd_en || host_rd_gnt;
    assign sys_rd_addr = host_rd_gnt ? host_rd_addr : (stream_rd_en ? rd_addr : '0);
    // sys_data_out is already the systemizer's registered read port, aligned with host_rd_valid.
    assign host_data   = host_rd_valid ? sys_data_out : '0;

    assign busy   = (state != ST_IDLE);
    assign key_ok = (state == ST_FINISH);

    always_comb begin
        state_nxt   = state;
        gen_req_nxt = 1'b0;
        abort_nxt   = 1'b0;
        tries_nxt   = tries;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt   = ST_GEN;
                    gen_req_nxt = 1'b1;
                    tries_nxt   = TW'(1);
                end
            end
            ST_GEN: begin
                if (gen_done) state_nxt = ST_SYS_START;
            end
            ST_SYS_START: state_nxt = ST_SYS_WAIT;
            ST_SYS_WAIT: begin
                if (sys_fail) begin
                    if (tries == TW'(MAX_TRIES)) begin
                        state_nxt = ST_IDLE;
                        abort_nxt = 1'b1;
                    end else begin
                        state_nxt   = ST_GEN;
                        gen_req_nxt = 1'b1;
                        tries_nxt   = tries + TW'(1);
                    end
                end else if (sys_success) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (pop && strm.out_last) state_nxt = ST_FINISH;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            gen_req       <= 1'b0;
            sys_start     <= 1'b0;
            key_abort     <= 1'b0;
            tries         <= '0;
            host_rd_valid <= 1'b0;
            rd_pend       <= 1'b0;
            rd_addr       <= '0;
            rd_all        <= 1'b0;
            out_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            gen_req       <= gen_req_nxt;
            sys_start     <= (state == ST_SYS_START);
            key_abort     <= abort_nxt;
            tries         <= tries_nxt;
            host_rd_valid <= host_rd_gnt;
            rd_pend       <= stream_rd_en;
            if (state == ST_SYS_WAIT) begin
                rd_addr <= '0;
                rd_all  <= 1'b0;
                out_cnt <= '0;
            end else begin
                if (stream_rd_en) begin
                    if (rd_addr == AW'(WORDS - 1)) rd_all  <= 1'b1;
                    else                           rd_addr <= rd_addr + AW'(1);
                end
                if (pop) out_cnt <= out_cnt + AW'(1);
            end
        end
    end

endmodule
